// File: rtl/score_pkg.sv
// Shared types and constants for the score command arbiter.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] P3 = 3'b011;

  function automatic logic is_valid_player(input logic [2:0] code);
    return (code == P1) || (code == P2) || (code == P3);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr,
// wrapping to the lowest index when nothing at or above ptr is requesting.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    // Wrap-around pass: only reached when nothing at or above ptr requested.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/score_cmd_arbiter.sv
// Round-robin arbiter serialising judge add/sub requests into clean chose/add/sub
// sequences for the score datapath. Optional SCORE_ARB_STATS_EN enables cmd_count.
module score_cmd_arbiter
  import score_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [3*NUM_REQ-1:0]   req_player,
  input  logic                   lock,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   add,
  output logic                   sub,
  output logic [2:0]             chose,
  output logic                   busy,
  output logic                   err_drop,
  output logic [7:0]             cmd_count
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 op_q, op_d;
  logic [2:0]           player_q, player_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_drop_q, err_drop_d;
  logic                 add_q, add_d;
  logic                 sub_q, sub_d;
  logic [2:0]           chose_q, chose_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   req_eff, grant;
  logic                 any_req;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_op;
  logic [2:0]           win_player;

  // A request acked this cycle is still high by protocol; it must not win again.
  assign req_eff = req & ~ack_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_eff),
    .ptr     (ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    win_idx    = '0;
    win_op     = OP_SUB;
    win_player = 3'b000;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        win_idx    = PTR_W'(i);
        win_op     = req_op[i];
        win_player = req_player[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      op_q       <= OP_SUB;
      player_q   <= 3'b000;
      ack_q      <= '0;
      err_drop_q <= 1'b0;
      add_q      <= 1'b0;
      sub_q      <= 1'b0;
      chose_q    <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      player_q   <= player_d;
      ack_q      <= ack_d;
      err_drop_q <= err_drop_d;
      add_q      <= add_d;
      sub_q      <= sub_d;
      chose_q    <= chose_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    player_d   = player_q;
    ack_d      = '0;
    err_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lock && any_req) begin
          ack_d = grant;
          ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          if (is_valid_player(win_player)) begin
            state_d  = SETUP;
            op_d     = win_op;
            player_d = win_player;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes lag the state by one register so chose settles a full cycle before add/sub.
  always_comb begin
    add_d   = 1'b0;
    sub_d   = 1'b0;
    chose_d = chose_q;
    busy_d  = (state_d != IDLE);
    if (state_q == SETUP) begin
      chose_d = player_q;
    end
    if (state_q == PULSE) begin
      add_d = (op_q == OP_ADD);
      sub_d = (op_q == OP_SUB);
    end
  end

  assign ack      = ack_q;
  assign err_drop = err_drop_q;
  assign add      = add_q;
  assign sub      = sub_q;
  assign chose    = chose_q;
  assign busy     = busy_q;

`ifdef SCORE_ARB_STATS_EN
  logic [7:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if ((state_q == IDLE) && (state_d == SETUP)) begin
      cmd_count_d = cmd_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cmd_count_q <= 8'd0;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd_count = cmd_count_q;
`else
  assign cmd_count = 8'd0;
`endif

endmodule

// File: tb/tb_score_cmd_arbiter.sv
// Self-checking bench for score_cmd_arbiter: directed scenarios plus a randomized
// run checked against a cycle-timeline reference model.
`timescale 1ns/1ps
module tb_score_cmd_arbiter;

  localparam int N = 3;
  localparam int P = 2;
  localparam int G = 4;
`ifdef SCORE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clr;
  logic [N-1:0]   req;
  logic [N-1:0]   req_op;
  logic [3*N-1:0] req_player;
  logic           lock;
  logic [N-1:0]   ack;
  logic           add;
  logic           sub;
  logic [2:0]     chose;
  logic           busy;
  logic           err_drop;
  logic [7:0]     cmd_count;

  int errors = 0;
  int checks = 0;

  score_cmd_arbiter #(.NUM_REQ(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .req_op     (req_op),
    .req_player (req_player),
    .lock       (lock),
    .ack        (ack),
    .add        (add),
    .sub        (sub),
    .chose      (chose),
    .busy       (busy),
    .err_drop   (err_drop),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_op = '0; req_player = '0; lock = 1'b0;
    clr = 1'b1;
    next_cycle();
    next_cycle();
    clr = 1'b0;
  endtask

  function automatic logic [2:0] rand_player();
    if ($urandom_range(0, 5) == 0) return 3'($urandom_range(0, 7));
    return 3'($urandom_range(1, 3));
  endfunction

  task automatic issue(input int idx, input logic op, input logic [2:0] pl, output bit ok);
    int t;
    ok = 1'b1;
    req_op[idx] = op;
    req_player[3*idx +: 3] = pl;
    req[idx] = 1'b1;
    t = 0;
    do begin next_cycle(); t++; end while (ack[idx] !== 1'b1 && t < 30);
    if (ack[idx] !== 1'b1) ok = 1'b0;
    next_cycle();
    req[idx] = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 30) begin next_cycle(); t++; end
    if (busy === 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; req_op = '0; req_player = '0; lock = 1'b0;
    clr = 1'b1;
    #2;
    checks++;
    if ({ack, add, sub, busy, err_drop} !== 7'd0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000000", {ack, add, sub, busy, err_drop});
    end
    checks++;
    if (chose !== 3'b000) begin errors++; $display("FAIL reset_chose: got %b want 000", chose); end
    checks++;
    if (cmd_count !== 8'd0) begin errors++; $display("FAIL reset_cmd_count: got %0d want 0", cmd_count); end
    next_cycle();
    clr = 1'b0;
    next_cycle();
    checks++;
    if ({ack, busy} !== 4'd0) begin errors++; $display("FAIL reset_idle: got %b want 0000", {ack, busy}); end
  endtask

  task automatic test_clr_mid_pulse();
    do_reset();
    req = 3'b001; req_op = 3'b001; req_player = 9'b000_000_010;
    next_cycle();
    next_cycle();
    req = '0;
    next_cycle();
    checks++;
    if (add !== 1'b1) begin errors++; $display("FAIL clr_pre_add: got %b want 1", add); end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({add, sub, busy} !== 3'b000) begin errors++; $display("FAIL clr_async_drop: add/sub/busy got %b want 000", {add, sub, busy}); end
    checks++;
    if (chose !== 3'b000) begin errors++; $display("FAIL clr_chose: got %b want 000", chose); end
    checks++;
    if (cmd_count !== 8'd0) begin errors++; $display("FAIL clr_cmd_count: got %0d want 0", cmd_count); end
    next_cycle();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      checks++;
      if ({ack, busy, add} !== 5'd0) begin errors++; $display("FAIL clr_no_repeat: ack/busy/add got %b want 0", {ack, busy, add}); end
    end
  endtask

  task automatic test_single_add();
    int busy_cycles;
    logic exp_add;
    do_reset();
    req = 3'b001; req_op = 3'b001; req_player = 9'b000_000_010;
    busy_cycles = 0;
    next_cycle();
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) req = '0;
      exp_add = (k == 3) || (k == 4);
      checks++;
      if (add !== exp_add || sub !== 1'b0) begin
        errors++; $display("FAIL single_add_window k=%0d: add/sub got %b%b want %b0", k, add, sub, exp_add);
      end
      checks++;
      if (ack !== ((k == 1) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL single_ack k=%0d: got %b want %b", k, ack, (k == 1) ? 3'b001 : 3'b000);
      end
      checks++;
      if (chose !== ((k >= 2) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL single_chose k=%0d: got %b want %b", k, chose, (k >= 2) ? 3'b010 : 3'b000);
      end
      if (busy === 1'b1) busy_cycles++;
      next_cycle();
    end
    checks++;
    if (busy_cycles != 1 + P + G) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_cycles, 1 + P + G); end
  endtask

  task automatic test_round_robin();
    int n_acks, cyc;
    int ack_cyc[4];
    int ack_id[4];
    logic [N-1:0] prev_ack;
    do_reset();
    req_op = 3'b101;
    req_player = 9'b011_010_001;
    req = 3'b111;
    n_acks = 0; cyc = 0; prev_ack = '0;
    while (n_acks < 4 && cyc < 60) begin
      next_cycle();
      cyc++;
      req = 3'b111 & ~prev_ack;
      checks++;
      if (add === 1'b1 && sub === 1'b1) begin errors++; $display("FAIL rr_overlap: add and sub both high at cycle %0d", cyc); end
      if (ack !== '0) begin
        for (int i = 0; i < N; i++) if (ack[i] === 1'b1) ack_id[n_acks] = i;
        checks++;
        if (!$onehot(ack)) begin errors++; $display("FAIL rr_onehot: got %b want one-hot", ack); end
        ack_cyc[n_acks] = cyc;
        n_acks++;
      end
      prev_ack = ack;
    end
    checks++;
    if (n_acks != 4) begin errors++; $display("FAIL rr_timeout: got %0d acks want 4", n_acks); end
    for (int j = 0; j < n_acks; j++) begin
      checks++;
      if (ack_id[j] != j % N) begin errors++; $display("FAIL rr_order grant %0d: got %0d want %0d", j, ack_id[j], j % N); end
      if (j > 0) begin
        checks++;
        if (ack_cyc[j] - ack_cyc[j-1] != 2 + P + G) begin
          errors++; $display("FAIL rr_spacing grant %0d: got %0d want %0d", j, ack_cyc[j] - ack_cyc[j-1], 2 + P + G);
        end
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 3'b010; req_op = 3'b111; req_player = 9'b001_100_001;
    next_cycle();
    checks++;
    if (ack !== 3'b010) begin errors++; $display("FAIL drop_ack: got %b want 010", ack); end
    checks++;
    if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", err_drop); end
    checks++;
    if ({busy, add, sub} !== 3'b000) begin errors++; $display("FAIL drop_quiet: busy/add/sub got %b want 000", {busy, add, sub}); end
    next_cycle();
    req = 3'b101;
    checks++;
    if ({err_drop, ack, busy, add, sub} !== 7'd0) begin
      errors++; $display("FAIL drop_one_shot: err/ack/busy/add/sub got %b want 0", {err_drop, ack, busy, add, sub});
    end
    next_cycle();
    checks++;
    if (ack !== 3'b100) begin errors++; $display("FAIL drop_next_scan: got %b want 100", ack); end
    next_cycle();
    req = '0;
    repeat (12) next_cycle();
  endtask

  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    req = 3'b100; req_op = 3'b100; req_player = 9'b011_000_000;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      checks++;
      if ({ack, busy} !== 4'd0) begin errors++; $display("FAIL lock_hold k=%0d: ack/busy got %b want 0000", k, {ack, busy}); end
    end
    lock = 1'b0;
    next_cycle();
    checks++;
    if (ack !== 3'b100) begin errors++; $display("FAIL lock_release_ack: got %b want 100", ack); end
    next_cycle();
    req = '0;
    next_cycle();
    checks++;
    if (add !== 1'b1) begin errors++; $display("FAIL lock_add1: got %b want 1", add); end
    next_cycle();
    checks++;
    if (add !== 1'b1) begin errors++; $display("FAIL lock_add2: got %b want 1", add); end
    next_cycle();
    lock = 1'b1;
    req[0] = 1'b1; req_op[0] = 1'b1; req_player[2:0] = 3'b001;
    next_cycle();
    next_cycle();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL lock_gap_busy: got %b want 1", busy); end
    next_cycle();
    checks++;
    if ({busy, add} !== 2'b00) begin errors++; $display("FAIL lock_gap_done: busy/add got %b want 00", {busy, add}); end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL lock_no_grant k=%0d: got %b want 000", k, ack); end
    end
    lock = 1'b0;
    req = '0;
  endtask

  task automatic test_stats();
    bit ok;
    do_reset();
    issue(0, 1'b1, 3'b001, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stats_issue0: handshake timed out"); end
    checks++;
    if (cmd_count !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL stats_count1: got %0d want %0d", cmd_count, STATS ? 1 : 0); end
    issue(1, 1'b0, 3'b010, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stats_issue1: handshake timed out"); end
    issue(2, 1'b1, 3'b110, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stats_issue_drop: handshake timed out"); end
    issue(0, 1'b1, 3'b011, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stats_issue3: handshake timed out"); end
    checks++;
    if (cmd_count !== (STATS ? 8'd3 : 8'd0)) begin errors++; $display("FAIL stats_count3: got %0d want %0d", cmd_count, STATS ? 3 : 0); end
  endtask

  // Reference model: each valid grant at cycle g defines a fixed output timeline.
  task automatic test_random();
    int g, free_at, ptr, w, exp_cnt;
    bit pend_inc;
    logic m_op;
    logic [2:0] m_player, m_chose, pl;
    logic [N-1:0] exp_ack, pend_ack, masked, prev_seen;
    logic exp_err, pend_err, exp_add, exp_sub, exp_busy;
    do_reset();
    g = -100; free_at = 0; ptr = 0; exp_cnt = 0; pend_inc = 1'b0;
    m_op = 1'b0; m_player = 3'b000; m_chose = 3'b000;
    pend_ack = '0; pend_err = 1'b0; prev_seen = '0;
    for (int c = 0; c < 500; c++) begin
      exp_ack = pend_ack; exp_err = pend_err;
      if (pend_inc) exp_cnt = (exp_cnt + 1) % 256;
      pend_ack = '0; pend_err = 1'b0; pend_inc = 1'b0;
      if (c == g + 2) m_chose = m_player;
      exp_add  = (c >= g + 3) && (c <= g + 2 + P) && m_op;
      exp_sub  = (c >= g + 3) && (c <= g + 2 + P) && !m_op;
      exp_busy = (c >= g + 1) && (c <= g + 1 + P + G);
      checks++;
      if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack c=%0d: got %b want %b", c, ack, exp_ack); end
      checks++;
      if (err_drop !== exp_err) begin errors++; $display("FAIL rand_err c=%0d: got %b want %b", c, err_drop, exp_err); end
      checks++;
      if (add !== exp_add) begin errors++; $display("FAIL rand_add c=%0d: got %b want %b", c, add, exp_add); end
      checks++;
      if (sub !== exp_sub) begin errors++; $display("FAIL rand_sub c=%0d: got %b want %b", c, sub, exp_sub); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, exp_busy); end
      checks++;
      if (chose !== m_chose) begin errors++; $display("FAIL rand_chose c=%0d: got %b want %b", c, chose, m_chose); end
      checks++;
      if (cmd_count !== (STATS ? 8'(exp_cnt) : 8'd0)) begin
        errors++; $display("FAIL rand_cmd_count c=%0d: got %0d want %0d", c, cmd_count, STATS ? exp_cnt : 0);
      end
      for (int i = 0; i < N; i++) begin
        if (prev_seen[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_op[i] = 1'($urandom_range(0, 1));
            req_player[3*i +: 3] = rand_player();
          end
        end else if (ack[i] !== 1'b1 && $urandom_range(0, 3) == 0) begin
          req_op[i] = 1'($urandom_range(0, 1));
          req_player[3*i +: 3] = rand_player();
        end
      end
      prev_seen = ack;
      lock = ($urandom_range(0, 6) == 0);
      if (c >= free_at && !lock) begin
        masked = req & ~exp_ack;
        w = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (ptr + k) % N;
          if (w < 0 && masked[idx]) w = idx;
        end
        if (w >= 0) begin
          pend_ack = N'(1 << w);
          ptr = (w + 1) % N;
          pl = req_player[3*w +: 3];
          if (pl >= 3'd1 && pl <= 3'd3) begin
            g = c; m_op = req_op[w]; m_player = pl;
            free_at = c + 2 + P + G;
            pend_inc = 1'b1;
          end else begin
            pend_err = 1'b1;
          end
        end
      end
      next_cycle();
    end
    req = '0;
    lock = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clr_mid_pulse();
    test_single_add();
    test_round_robin();
    test_drop();
    test_lock();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
